// File: rtl/class_hv_binarizer.sv
// Walks every stored class HV chunk by chunk, thresholds the per-dim counters into a binary chunk,
// streams it out over a valid/ready port and reports the per-class popcount.
module class_hv_binarizer #(
   parameter  int NUM_CLASSES      = 10,
   parameter  int CHUNKS_PER_HV    = 16,
   parameter  int DIMS_PER_CC      = 64,
   parameter  int BITWIDTH_PER_DIM = 8,
   localparam int CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   localparam int CHK_W  = (CHUNKS_PER_HV > 1) ? $clog2(CHUNKS_PER_HV) : 1,
   localparam int ONES_W = $clog2(CHUNKS_PER_HV*DIMS_PER_CC+1)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [BITWIDTH_PER_DIM-1:0]            threshold,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   binarizing_class_hvs,
   output logic                                   mem_rd_en,
   output logic [CLS_W-1:0]                       mem_rd_class,
   output logic [CHK_W-1:0]                       mem_rd_chunk,
   input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] mem_rd_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [CLS_W-1:0]                       out_class,
   output logic [CHK_W-1:0]                       out_chunk,
   output logic [DIMS_PER_CC-1:0]                 out_chunk_data,
   output logic                                   class_ones_valid,
   output logic [ONES_W-1:0]                      class_ones,
   output logic [1:0]                             dbg_state
);

   // Output port handshake: a chunk transfers in any cycle where out_valid && out_ready; while
   // out_valid is high and out_ready low, out_class/out_chunk/out_chunk_data hold stable.

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

   localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(NUM_CLASSES-1);
   localparam logic [CHK_W-1:0] LAST_CHUNK = CHK_W'(CHUNKS_PER_HV-1);

   state_t                      state, state_nxt;
   logic [BITWIDTH_PER_DIM-1:0] thr_q;
   logic                        rd_pending;
   logic [CLS_W-1:0]            pend_class;
   logic [CHK_W-1:0]            pend_chunk;
   logic [ONES_W-1:0]           ones_acc;
   logic [ONES_W-1:0]           chunk_ones;
   logic [DIMS_PER_CC-1:0]      cmp_bits;
   logic                        out_fire;
   logic                        last_out;

   assign out_fire             = out_valid && out_ready;
   assign last_out             = out_fire && (out_class == LAST_CLASS) && (out_chunk == LAST_CHUNK);
   assign binarizing_class_hvs = busy;
   assign dbg_state            = state;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A read may go out only when nothing is in flight and the output slot will be free for its data.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy      = 1'b1;
            mem_rd_en = !rd_pending && (!out_valid || out_ready);
            if (mem_rd_en && (mem_rd_class == LAST_CLASS) && (mem_rd_chunk == LAST_CHUNK))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (last_out) state_nxt = FIN;
         end
         FIN: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmp_bits = '0;
      for (int i = 0; i < DIMS_PER_CC; i++)
         cmp_bits[i] = (mem_rd_data[i*BITWIDTH_PER_DIM +: BITWIDTH_PER_DIM] >= thr_q);
   end

   always_comb begin
      chunk_ones = '0;
      for (int i = 0; i < DIMS_PER_CC; i++)
         chunk_ones = chunk_ones + ONES_W'(out_chunk_data[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         thr_q            <= '0;
         rd_pending       <= 1'b0;
         pend_class       <= '0;
         pend_chunk       <= '0;
         mem_rd_class     <= '0;
         mem_rd_chunk     <= '0;
         out_valid        <= 1'b0;
         out_class        <= '0;
         out_chunk        <= '0;
         out_chunk_data   <= '0;
         ones_acc         <= '0;
         class_ones       <= '0;
         class_ones_valid <= 1'b0;
      end else begin
         class_ones_valid <= 1'b0;
         rd_pending       <= mem_rd_en;

         if ((state == IDLE) && start) begin
            thr_q        <= threshold;
            mem_rd_class <= '0;
            mem_rd_chunk <= '0;
            ones_acc     <= '0;
         end

         if (mem_rd_en) begin
            pend_class <= mem_rd_class;
            pend_chunk <= mem_rd_chunk;
            if (mem_rd_chunk == LAST_CHUNK) begin
               mem_rd_chunk <= '0;
               mem_rd_class <= (mem_rd_class == LAST_CLASS) ? '0 : mem_rd_class + CLS_W'(1);
            end else begin
               mem_rd_chunk <= mem_rd_chunk + CHK_W'(1);
            end
         end

         // Returning data always finds the slot free, so capture never collides with a held chunk.
         if (rd_pending) begin
            out_valid      <= 1'b1;
            out_class      <= pend_class;
            out_chunk      <= pend_chunk;
            out_chunk_data <= cmp_bits;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end

         if (out_fire) begin
            if (out_chunk == LAST_CHUNK) begin
               class_ones       <= ones_acc + chunk_ones;
               class_ones_valid <= 1'b1;
               ones_acc         <= '0;
            end else begin
               ones_acc <= ones_acc + chunk_ones;
            end
         end
      end
   end

endmodule
